// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : Registered execute stage: ALU control decode, 32-bit ALU with
//            flags, PC+4 and branch-target adders, one register stage.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int WIDTH  = 32,
    parameter int PC_INC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] pc,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [WIDTH-1:0] imm,
    input  logic             branch,
    output logic             out_valid,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] branch_target,
    output logic             branch_taken
);

    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;
    localparam logic [3:0] c_ALU_NOR = 4'b1100;
    localparam logic [3:0] c_ALU_INV = 4'b1111;

    localparam logic [WIDTH-1:0] c_PC_INC = WIDTH'(PC_INC);

    logic [3:0]       w_alu_ctrl;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_result;
    logic             w_overflow;
    logic             w_zero;
    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_branch_target;

    always_comb begin
        w_alu_ctrl = c_ALU_INV;
        case (alu_op)
            2'b00:   w_alu_ctrl = c_ALU_ADD;
            2'b01:   w_alu_ctrl = c_ALU_SUB;
            2'b11:   w_alu_ctrl = c_ALU_ADD;
            default: begin
                case (funct)
                    6'b100000: w_alu_ctrl = c_ALU_ADD;
                    6'b100010: w_alu_ctrl = c_ALU_SUB;
                    6'b100100: w_alu_ctrl = c_ALU_AND;
                    6'b100101: w_alu_ctrl = c_ALU_OR;
                    6'b100111: w_alu_ctrl = c_ALU_NOR;
                    6'b101010: w_alu_ctrl = c_ALU_SLT;
                    default:   w_alu_ctrl = c_ALU_INV;
                endcase
            end
        endcase
    end

    assign w_sum  = operand_a + operand_b;
    assign w_diff = operand_a - operand_b;

    always_comb begin
        w_result   = '0;
        w_overflow = 1'b0;
        case (w_alu_ctrl)
            c_ALU_AND: w_result = operand_a & operand_b;
            c_ALU_OR:  w_result = operand_a | operand_b;
            c_ALU_ADD: begin
                w_result   = w_sum;
                w_overflow = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != operand_a[WIDTH-1]);
            end
            c_ALU_SUB: begin
                w_result   = w_diff;
                w_overflow = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                             (w_diff[WIDTH-1] != operand_a[WIDTH-1]);
            end
            c_ALU_SLT: w_result = {{(WIDTH-1){1'b0}},
                                   ($signed(operand_a) < $signed(operand_b))};
            c_ALU_NOR: w_result = ~(operand_a | operand_b);
            default:   w_result = '0;
        endcase
    end

    assign w_zero          = (w_result == '0);
    assign w_pc_plus4      = pc + c_PC_INC;
    assign w_branch_target = w_pc_plus4 + {imm[WIDTH-3:0], 2'b00};

    // Data outputs hold on idle cycles; only out_valid tracks in_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid     <= 1'b0;
            alu_ctrl      <= '0;
            result        <= '0;
            zero          <= 1'b0;
            overflow      <= 1'b0;
            pc_plus4      <= '0;
            branch_target <= '0;
            branch_taken  <= 1'b0;
        end else if (in_valid) begin
            out_valid     <= 1'b1;
            alu_ctrl      <= w_alu_ctrl;
            result        <= w_result;
            zero          <= w_zero;
            overflow      <= w_overflow;
            pc_plus4      <= w_pc_plus4;
            branch_target <= w_branch_target;
            branch_taken  <= branch & w_zero;
        end else begin
            out_valid     <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Purpose  : Directed self-checking bench for alu_exec_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam int WIDTH = 32;

    localparam logic [5:0] c_F_ADD = 6'b100000;
    localparam logic [5:0] c_F_SUB = 6'b100010;
    localparam logic [5:0] c_F_AND = 6'b100100;
    localparam logic [5:0] c_F_OR  = 6'b100101;
    localparam logic [5:0] c_F_NOR = 6'b100111;
    localparam logic [5:0] c_F_SLT = 6'b101010;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] pc;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] imm;
    logic             branch;
    logic             out_valid;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] branch_target;
    logic             branch_taken;

    int n_checks = 0;
    int n_pass   = 0;

    alu_exec_unit #(.WIDTH(WIDTH), .PC_INC(4)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .pc            (pc),
        .alu_op        (alu_op),
        .funct         (funct),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .imm           (imm),
        .branch        (branch),
        .out_valid     (out_valid),
        .alu_ctrl      (alu_ctrl),
        .result        (result),
        .zero          (zero),
        .overflow      (overflow),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .branch_taken  (branch_taken)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, ".out_valid"},     32'(out_valid),    32'd0);
        check_val({tag, ".alu_ctrl"},      32'(alu_ctrl),     32'd0);
        check_val({tag, ".result"},        result,            32'd0);
        check_val({tag, ".zero"},          32'(zero),         32'd0);
        check_val({tag, ".overflow"},      32'(overflow),     32'd0);
        check_val({tag, ".pc_plus4"},      pc_plus4,          32'd0);
        check_val({tag, ".branch_target"}, branch_target,     32'd0);
        check_val({tag, ".branch_taken"},  32'(branch_taken), 32'd0);
    endtask

    // Drive one cycle of inputs just after a rising edge, then return #1 after the
    // next rising edge so the registered outputs can be sampled.
    task automatic do_op(input logic v, input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] im, input logic br);
        in_valid  = v;
        alu_op    = op;
        funct     = f;
        operand_a = a;
        operand_b = b;
        pc        = p;
        imm       = im;
        branch    = br;
        @(posedge clk);
        #1;
    endtask

    task automatic check_alu(input string tag, input logic [3:0] ctrl,
                             input logic [31:0] res, input logic z, input logic ov);
        check_val({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check_val({tag, ".alu_ctrl"},  32'(alu_ctrl),  32'(ctrl));
        check_val({tag, ".result"},    result,         res);
        check_val({tag, ".zero"},      32'(zero),      32'(z));
        check_val({tag, ".overflow"},  32'(overflow),  32'(ov));
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b1; alu_op = 2'b00; funct = 6'd0; branch = 1'b1;
        operand_a = 32'd1; operand_b = 32'd2; pc = 32'h100; imm = 32'd3;
        #1;
        check_cleared("rst_t0");
        for (int i = 0; i < 3; i++) begin
            do_op(1'b1, 2'($urandom_range(0, 3)), 6'($urandom), $urandom, $urandom,
                  $urandom | 32'h10, $urandom, 1'b1);
            check_cleared("rst_held");
        end

        rst = 1'b1;
        do_op(1'b1, 2'b00, 6'd0, 32'd5, 32'd7, 32'h0, 32'h0, 1'b0);
        check_alu("first_add", 4'b0010, 32'd12, 1'b0, 1'b0);

        // R-type sweep
        do_op(1'b1, 2'b10, c_F_ADD, 32'h0F, 32'hF0, 32'h0, 32'h0, 1'b0);
        check_alu("r_add", 4'b0010, 32'h000000FF, 1'b0, 1'b0);
        do_op(1'b1, 2'b10, c_F_SUB, 32'h0F, 32'hF0, 32'h0, 32'h0, 1'b0);
        check_alu("r_sub", 4'b0110, 32'hFFFFFF1F, 1'b0, 1'b0);
        do_op(1'b1, 2'b10, c_F_AND, 32'h0F, 32'hF0, 32'h0, 32'h0, 1'b0);
        check_alu("r_and", 4'b0000, 32'h0, 1'b1, 1'b0);
        do_op(1'b1, 2'b10, c_F_OR, 32'h0F, 32'hF0, 32'h0, 32'h0, 1'b0);
        check_alu("r_or", 4'b0001, 32'h000000FF, 1'b0, 1'b0);
        do_op(1'b1, 2'b10, c_F_NOR, 32'h0F, 32'hF0, 32'h0, 32'h0, 1'b0);
        check_alu("r_nor", 4'b1100, 32'hFFFFFF00, 1'b0, 1'b0);
        do_op(1'b1, 2'b10, c_F_SLT, 32'h0F, 32'hF0, 32'h0, 32'h0, 1'b0);
        check_alu("r_slt", 4'b0111, 32'h1, 1'b0, 1'b0);
        do_op(1'b1, 2'b10, 6'b000000, 32'h0F, 32'hF0, 32'h0, 32'h0, 1'b0);
        check_alu("r_inv", 4'b1111, 32'h0, 1'b1, 1'b0);

        // Signed edges
        do_op(1'b1, 2'b10, c_F_SLT, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1'b0);
        check_alu("slt_neg", 4'b0111, 32'h1, 1'b0, 1'b0);
        do_op(1'b1, 2'b10, c_F_SLT, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0);
        check_alu("slt_pos", 4'b0111, 32'h0, 1'b1, 1'b0);
        do_op(1'b1, 2'b10, c_F_ADD, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 1'b0);
        check_alu("add_ovf", 4'b0010, 32'h80000000, 1'b0, 1'b1);
        do_op(1'b1, 2'b10, c_F_SUB, 32'h80000000, 32'h1, 32'h0, 32'h0, 1'b0);
        check_alu("sub_ovf", 4'b0110, 32'h7FFFFFFF, 1'b0, 1'b1);
        do_op(1'b1, 2'b10, c_F_OR, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h0, 1'b0);
        check_alu("or_no_ovf", 4'b0001, 32'h7FFFFFFF, 1'b0, 1'b0);

        // Branch taken / not taken
        do_op(1'b1, 2'b01, 6'd0, 32'h1234, 32'h1234, 32'h00400010, 32'hFFFFFFFE, 1'b1);
        check_alu("beq_eq", 4'b0110, 32'h0, 1'b1, 1'b0);
        check_val("beq_eq.taken",  32'(branch_taken), 32'd1);
        check_val("beq_eq.pc4",    pc_plus4,          32'h00400014);
        check_val("beq_eq.target", branch_target,     32'h0040000C);
        do_op(1'b1, 2'b01, 6'd0, 32'h1234, 32'h1235, 32'h00400010, 32'hFFFFFFFE, 1'b1);
        check_alu("beq_ne", 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b0);
        check_val("beq_ne.taken", 32'(branch_taken), 32'd0);
        do_op(1'b1, 2'b00, 6'd0, 32'h0, 32'h0, 32'h00001000, 32'h00000010, 1'b0);
        check_val("nobr.taken",  32'(branch_taken), 32'd0);
        check_val("fwd.target",  branch_target,     32'h00001044);

        // PC wrap, then hold through idle cycles
        do_op(1'b1, 2'b11, 6'd0, 32'd3, 32'd4, 32'hFFFFFFFC, 32'h1, 1'b0);
        check_alu("wrap", 4'b0010, 32'd7, 1'b0, 1'b0);
        check_val("wrap.pc4",    pc_plus4,      32'h0);
        check_val("wrap.target", branch_target, 32'h4);
        for (int i = 0; i < 3; i++) begin
            do_op(1'b0, 2'b10, c_F_NOR, 32'h11 * (i + 1), 32'h5, 32'h2000 + i, 32'h7, 1'b1);
            check_val("hold.out_valid", 32'(out_valid),    32'd0);
            check_val("hold.result",    result,            32'd7);
            check_val("hold.alu_ctrl",  32'(alu_ctrl),     32'd2);
            check_val("hold.pc4",       pc_plus4,          32'h0);
            check_val("hold.target",    branch_target,     32'h4);
            check_val("hold.taken",     32'(branch_taken), 32'd0);
        end

        // Back-to-back with an asynchronous reset pulse mid-stream
        do_op(1'b1, 2'b10, c_F_AND, 32'hFF00FF00, 32'h0FF00FF0, 32'h10, 32'h0, 1'b0);
        check_alu("b2b_and", 4'b0000, 32'h0F000F00, 1'b0, 1'b0);
        do_op(1'b1, 2'b10, c_F_SUB, 32'd100, 32'd100, 32'h20, 32'h0, 1'b1);
        check_alu("b2b_sub", 4'b0110, 32'h0, 1'b1, 1'b0);
        check_val("b2b_sub.taken", 32'(branch_taken), 32'd1);
        check_val("b2b_sub.pc4",   pc_plus4,          32'h24);
        in_valid = 1'b1; alu_op = 2'b00; operand_a = 32'd9; operand_b = 32'd1;
        rst = 1'b0;
        #2;
        check_cleared("mid_rst");
        @(posedge clk);
        #1;
        check_cleared("mid_rst_edge");
        rst = 1'b1;
        do_op(1'b1, 2'b00, 6'd0, 32'd9, 32'd1, 32'h30, 32'h0, 1'b0);
        check_alu("after_rst", 4'b0010, 32'd10, 1'b0, 1'b0);
        check_val("after_rst.pc4", pc_plus4, 32'h34);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
